// File: rtl/hbc_bus_pkg.sv
// Shared types and constants for the 8-bit host bus initiator.
//   HBC_DATA_W  : host bus data width
//   HBC_ADDR_W  : default host bus address width
//   hbc_state_t : transaction phase encoding
//   hbc_max3    : elaboration helper for sizing the phase counter
package hbc_bus_pkg;

    localparam int unsigned HBC_DATA_W = 8;
    localparam int unsigned HBC_ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } hbc_state_t;

    function automatic int unsigned hbc_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hbc_phase_timer.sv
// Loadable down-counter timing one bus phase.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload the counter with load_val (phase entry)
//   load_val  : phase length minus one
//   done      : counter has reached zero (last cycle of the phase)
module hbc_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Count down and park at zero until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/hbc_bus_master.sv
// Synchronous initiator for the 8-bit asynchronous host bus.
// Turns single-beat read/write requests into WRn/RDn strobe sequences with
// parameterized setup, strobe and hold lengths, and reports completion with a
// one-cycle response pulse.
//   req_*      : request handshake from the internal controller
//   rsp_*      : completion pulse and read data
//   bus_*      : registered pad-side strobes, address and data, plus pad input
module hbc_bus_master
    import hbc_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = HBC_ADDR_W,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [HBC_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [HBC_DATA_W-1:0] rsp_rdata,
    output logic                  bus_wr_n,
    output logic                  bus_rd_n,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [HBC_DATA_W-1:0] bus_data_out,
    output logic                  bus_data_oe,
    input  logic [HBC_DATA_W-1:0] bus_data_in
);

    localparam int unsigned MAX_CYC = hbc_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
        $error("hbc_bus_master: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
    end

    hbc_state_t state;
    hbc_state_t state_next;

    logic             write_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_done;

    logic                  accept;
    logic                  cur_write;
    logic                  on_bus;
    logic                  capture;
    logic                  wr_n_next;
    logic                  rd_n_next;
    logic                  oe_next;
    logic                  rsp_valid_next;
    logic [ADDR_W-1:0]     addr_next;
    logic [HBC_DATA_W-1:0] data_next;

    hbc_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .done    (tmr_done)
    );

    // Ready is a pure state decode, forced low while reset is asserted.
    assign req_ready = (state == IDLE) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, phase timer reload and next values of the registered outputs.
    always_comb begin
        state_next   = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next   = SETUP;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_next   = STROBE;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(STROBE_CYC - 1);
                end
            end
            STROBE: begin
                if (tmr_done) begin
                    state_next   = HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so the accepting edge
        // already has to see the incoming request fields.
        accept    = (state == IDLE) && req_valid;
        cur_write = accept ? req_write : write_q;
        on_bus    = (state_next == SETUP) || (state_next == STROBE) ||
                    (state_next == HOLD);

        wr_n_next      = !((state_next == STROBE) && cur_write);
        rd_n_next      = !((state_next == STROBE) && !cur_write);
        oe_next        = on_bus && cur_write;
        rsp_valid_next = (state_next == DONE);
        addr_next      = accept ? req_addr : bus_addr;
        data_next      = (accept && req_write) ? req_wdata : bus_data_out;

        // Sample read data on the edge that also raises RDn.
        capture = (state == STROBE) && tmr_done && !write_q;
    end

    // Registered request latch and bus/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q      <= 1'b0;
            bus_wr_n     <= 1'b1;
            bus_rd_n     <= 1'b1;
            bus_data_oe  <= 1'b0;
            bus_addr     <= '0;
            bus_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            if (accept) begin
                write_q <= req_write;
            end
            bus_wr_n     <= wr_n_next;
            bus_rd_n     <= rd_n_next;
            bus_data_oe  <= oe_next;
            bus_addr     <= addr_next;
            bus_data_out <= data_next;
            rsp_valid    <= rsp_valid_next;
            if (capture) begin
                rsp_rdata <= bus_data_in;
            end
        end
    end

endmodule

// File: doc/hbc_bus_master.md
# hbc_bus_master

Synchronous initiator for the team's 8-bit asynchronous parallel host bus: active-low WRn/RDn strobes, a small address bus and a shared 8-bit data bus. It converts single-beat read/write requests from internal `clk`-domain logic into strobe sequences with parameterized setup, strobe and hold timing. It returns read data or a write acknowledge on a response pulse. It sits between an internal controller and the top-level pads; the top-level wrapper builds the tri-state `inout` from `bus_data_out`/`bus_data_oe`/`bus_data_in`.

## Interface
- `ADDR_W`, 3, bus address width
- `SETUP_CYC`, 2, cycles address (and write data) are stable before the strobe falls; ≥1
- `STROBE_CYC`, 4, cycles the strobe is held low; ≥1, ≥2 for reads
- `HOLD_CYC`, 2, cycles address and write data are held after the strobe rises; ≥1
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle and accepting
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  target address
- `req_wdata`  in  8  write data
- `rsp_valid`  out  1  one-cycle pulse: transaction complete
- `rsp_rdata`  out  8  read data, valid with `rsp_valid` on reads; holds value until next read
- `bus_wr_n`  out  1  write strobe, active-low
- `bus_rd_n`  out  1  read strobe, active-low
- `bus_addr`  out  ADDR_W  bus address
- `bus_data_out`  out  8  write data to pads
- `bus_data_oe`  out  1  pad output enable
- `bus_data_in`  in  8  data from pads

## Operation
- States: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- IDLE: `req_ready`=1. When `req_valid`=1, latch write, addr and wdata, then go to SETUP.
- SETUP, SETUP_CYC cycles:
  - `bus_addr` driven.
  - On writes, `bus_data_out` is driven and `bus_data_oe`=1.
  - Both strobes stay high.
- STROBE, STROBE_CYC cycles: `bus_wr_n`=0 (write) or `bus_rd_n`=0 (read).
- Read capture: on the clock edge that ends the last STROBE cycle, `bus_data_in` is registered into `rsp_rdata`. The same edge raises `bus_rd_n`.
- HOLD, HOLD_CYC cycles:
  - Strobes high.
  - Address held.
  - On writes, data and `bus_data_oe` are held. The responder latches on the WRn rising edge, so data must stay stable past it.
- DONE, 1 cycle: `rsp_valid`=1. `bus_data_oe` drops on entry. `req_ready`=0.
- `bus_addr`/`bus_data_out` keep their last value in IDLE; no glitch-free requirement beyond registered outputs.
- `bus_data_oe` is never 1 while `bus_rd_n`=0. `bus_wr_n` and `bus_rd_n` are never both 0.
- Requests arriving outside IDLE are ignored (no buffering). The requester holds `req_valid` until it sees `req_ready`.

## Timing
- All bus outputs are registered; no combinational path from request inputs to bus pins.
- `req_ready` is decoded from the state register. It is 0 while `rst`=1.
- Accept at edge k: SETUP begins cycle k+1.
  - Strobe falls at start of cycle k+1+SETUP_CYC.
  - Strobe rises at start of cycle k+1+SETUP_CYC+STROBE_CYC.
  - `rsp_valid` is high in cycle k+1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - Next accept is possible in the following cycle.
- Throughput: one transaction per SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles.
- Reset values:
  - `bus_wr_n`=1, `bus_rd_n`=1
  - `bus_data_oe`=0
  - `bus_addr`=0, `bus_data_out`=0
  - `rsp_valid`=0, `rsp_rdata`=0
  - state IDLE
- Reset mid-transaction: at the next edge, strobes go high, oe goes 0 and state goes to IDLE; no `rsp_valid` is issued. A responder write may be spuriously latched if reset hits during STROBE; this is accepted.
- Phase counter width: $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1). It loads N−1 on phase entry and advances at 0.

## Structure
- Package `hbc_bus_pkg`:
  - state enum `hbc_state_t` (IDLE, SETUP, STROBE, HOLD, DONE)
  - `HBC_DATA_W`=8
  - default `HBC_ADDR_W`=3
- Sub-module `hbc_phase_timer`: loadable down-counter with `load`, `load_val` and `done` outputs, instantiated once and reloaded per phase.
- Elaboration-time check: each *_CYC ≥1.

## Test plan
- Write, defaults: req addr=5, wdata=0xA5 → `bus_wr_n` low exactly 4 cycles after 2 setup cycles; addr=5 and data=0xA5 with oe=1 stable from setup start until 2 cycles after WRn rises; a responder model latches 0xA5 at index 5; `rsp_valid` pulse once.
- Read: preload responder index 3 = 0x3C, read addr=3 → `bus_rd_n` low 4 cycles, oe=0 throughout; `rsp_rdata`=0x3C with `rsp_valid` at cycle k+9.
- Back-to-back: `req_valid` held high for write 0x11@0 then read @0 → second accept the cycle after the first DONE; read returns 0x11; `req_ready`=0 during the whole first transaction.
- Reset during STROBE of a write → next edge: `bus_wr_n`=1, oe=0, no `rsp_valid`, `req_ready`=1 after reset released.
- Minimum timing (all *_CYC=1, read): strobe low 1 cycle, capture still correct with a zero-delay model; `rsp_valid` at k+4.
- Protocol monitor across 1000 random transactions: never oe=1 with RDn=0, never both strobes low, address stable whenever either strobe is low.
